// File: rtl/ctrl_pipe_hazard_if.sv
// Pipeline control and hazard bundle.
// Decode-stage controls flow into the block.
// Stage registers, forward selects, stall controls and the stall counter flow out.
interface ctrl_pipe_hazard_if #(
   parameter int REGBITS = 5,
   parameter int CNTBITS = 16
);
   // decode stage
   logic                regwrited;
   logic                memtoregd;
   logic                memwrited;
   logic                alusrcd;
   logic                regdstd;
   logic                branchd;
   logic [1:0]          aluopd;
   logic [REGBITS-1:0]  rsd;
   logic [REGBITS-1:0]  rtd;
   logic [REGBITS-1:0]  rdd;

   // execute stage
   logic                regwritee;
   logic                memtorege;
   logic                memwritee;
   logic                alusrce;
   logic                regdste;
   logic [1:0]          aluope;
   logic [REGBITS-1:0]  rse;
   logic [REGBITS-1:0]  rte;
   logic [REGBITS-1:0]  rde;
   logic [REGBITS-1:0]  writerege;

   // memory stage
   logic                regwritem;
   logic                memtoregm;
   logic                memwritem;
   logic [REGBITS-1:0]  writeregm;

   // writeback stage
   logic                regwritew;
   logic                memtoregw;
   logic [REGBITS-1:0]  writeregw;

   // hazard unit
   logic [1:0]          forwardae;
   logic [1:0]          forwardbe;
   logic                forwardad;
   logic                forwardbd;
   logic                stallf;
   logic                stalld;
   logic                flushe;
   logic [CNTBITS-1:0]  stallcnt;

   // the decode-stage driver
   modport master (
      output regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd,
             aluopd, rsd, rtd, rdd,
      input  regwritee, memtorege, memwritee, alusrce, regdste, aluope,
             rse, rte, rde, writerege,
             regwritem, memtoregm, memwritem, writeregm,
             regwritew, memtoregw, writeregw,
             forwardae, forwardbe, forwardad, forwardbd,
             stallf, stalld, flushe, stallcnt
   );

   // the pipeline control / hazard block
   modport slave (
      input  regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd,
             aluopd, rsd, rtd, rdd,
      output regwritee, memtorege, memwritee, alusrce, regdste, aluope,
             rse, rte, rde, writerege,
             regwritem, memtoregm, memwritem, writeregm,
             regwritew, memtoregw, writeregw,
             forwardae, forwardbe, forwardad, forwardbd,
             stallf, stalld, flushe, stallcnt
   );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline for the E/M/W stages of a five-stage MIPS-style core.
// Also contains the hazard unit:
//   - execute and decode operand forwarding;
//   - load-use and branch stall detection;
//   - a saturating count of stall cycles.
module ctrl_pipe_hazard #(
   parameter int REGBITS = 5,
   parameter int CNTBITS = 16
) (
   input  logic              clk,
   input  logic              reset,
   ctrl_pipe_hazard_if.slave bus
);

   localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);
   localparam logic [CNTBITS-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic               regwrite;
      logic               memtoreg;
      logic               memwrite;
      logic               alusrc;
      logic               regdst;
      logic [1:0]         aluop;
      logic [REGBITS-1:0] rs;
      logic [REGBITS-1:0] rt;
      logic [REGBITS-1:0] rd;
   } e_stage_t;

   typedef struct packed {
      logic               regwrite;
      logic               memtoreg;
      logic               memwrite;
      logic [REGBITS-1:0] writereg;
   } m_stage_t;

   typedef struct packed {
      logic               regwrite;
      logic               memtoreg;
      logic [REGBITS-1:0] writereg;
   } w_stage_t;

   e_stage_t           e_reg, e_next;
   m_stage_t           m_reg, m_next;
   w_stage_t           w_reg, w_next;
   logic [CNTBITS-1:0] stallcnt_reg, stallcnt_next;

   logic [REGBITS-1:0] writereg_e;
   logic               lwstall;
   logic               branchstall;
   logic               stall;

   // Operand sources: index 0 is rs, index 1 is rt.
   logic [1:0][REGBITS-1:0] src_e;
   logic [1:0][REGBITS-1:0] src_d;
   logic [1:0][1:0]         fwd_e;
   logic [1:0]              fwd_d;
   logic [1:0]              lw_hit;
   logic [1:0]              br_e_hit;
   logic [1:0]              br_m_hit;

   assign writereg_e = e_reg.regdst ? e_reg.rd : e_reg.rt;

   assign src_e[0] = e_reg.rs;
   assign src_e[1] = e_reg.rt;
   assign src_d[0] = bus.rsd;
   assign src_d[1] = bus.rtd;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         // Register 0 is hard-wired zero, so it is never forwarded.
         // The M stage holds the younger result, so it wins over W.
         assign fwd_e[gi] =
            ((src_e[gi] != '0) && m_reg.regwrite && (src_e[gi] == m_reg.writereg)) ? 2'b10 :
            ((src_e[gi] != '0) && w_reg.regwrite && (src_e[gi] == w_reg.writereg)) ? 2'b01 :
                                                                                       2'b00;

         // Branch compare in decode can only take the M-stage ALU result.
         assign fwd_d[gi] = (src_d[gi] != '0) && m_reg.regwrite &&
                            (src_d[gi] == m_reg.writereg);

         // Stall compares deliberately include register 0.
         assign lw_hit[gi]   = (src_d[gi] == e_reg.rt);
         assign br_e_hit[gi] = (src_d[gi] == writereg_e);
         assign br_m_hit[gi] = (src_d[gi] == m_reg.writereg);
      end
   endgenerate

   assign lwstall     = e_reg.memtoreg && (|lw_hit);
   assign branchstall = bus.branchd &&
                        ((e_reg.regwrite && (|br_e_hit)) ||
                         (m_reg.memtoreg && (|br_m_hit)));
   assign stall       = lwstall || branchstall;

   // E stage takes the decode controls, or a bubble while the front end is held.
   always_comb begin
      e_next = '0;
      if (!stall) begin
         e_next.regwrite = bus.regwrited;
         e_next.memtoreg = bus.memtoregd;
         e_next.memwrite = bus.memwrited;
         e_next.alusrc   = bus.alusrcd;
         e_next.regdst   = bus.regdstd;
         e_next.aluop    = bus.aluopd;
         e_next.rs       = bus.rsd;
         e_next.rt       = bus.rtd;
         e_next.rd       = bus.rdd;
      end
   end

   // M and W stages simply advance each edge; they never stall or flush.
   always_comb begin
      m_next          = '0;
      m_next.regwrite = e_reg.regwrite;
      m_next.memtoreg = e_reg.memtoreg;
      m_next.memwrite = e_reg.memwrite;
      m_next.writereg = writereg_e;
      w_next          = '0;
      w_next.regwrite = m_reg.regwrite;
      w_next.memtoreg = m_reg.memtoreg;
      w_next.writereg = m_reg.writereg;
   end

   // The stall counter holds at all-ones instead of wrapping.
   // A cycle with both stall causes is counted once.
   always_comb begin
      stallcnt_next = stallcnt_reg;
      if (stall && (stallcnt_reg != CNT_MAX)) begin
         stallcnt_next = stallcnt_reg + CNT_ONE;
      end
   end

   // Pipeline and counter state.
   // Reset clears everything at once, whatever the clock is doing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_reg        <= '0;
         m_reg        <= '0;
         w_reg        <= '0;
         stallcnt_reg <= '0;
      end else begin
         e_reg        <= e_next;
         m_reg        <= m_next;
         w_reg        <= w_next;
         stallcnt_reg <= stallcnt_next;
      end
   end

   assign bus.regwritee = e_reg.regwrite;
   assign bus.memtorege = e_reg.memtoreg;
   assign bus.memwritee = e_reg.memwrite;
   assign bus.alusrce   = e_reg.alusrc;
   assign bus.regdste   = e_reg.regdst;
   assign bus.aluope    = e_reg.aluop;
   assign bus.rse       = e_reg.rs;
   assign bus.rte       = e_reg.rt;
   assign bus.rde       = e_reg.rd;
   assign bus.writerege = writereg_e;

   assign bus.regwritem = m_reg.regwrite;
   assign bus.memtoregm = m_reg.memtoreg;
   assign bus.memwritem = m_reg.memwrite;
   assign bus.writeregm = m_reg.writereg;

   assign bus.regwritew = w_reg.regwrite;
   assign bus.memtoregw = w_reg.memtoreg;
   assign bus.writeregw = w_reg.writereg;

   assign bus.forwardae = fwd_e[0];
   assign bus.forwardbe = fwd_e[1];
   assign bus.forwardad = fwd_d[0];
   assign bus.forwardbd = fwd_d[1];

   assign bus.stallf    = stall;
   assign bus.stalld    = stall;
   assign bus.flushe    = stall;
   assign bus.stallcnt  = stallcnt_reg;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Self-checking bench for ctrl_pipe_hazard.
// The model moves whole instruction packets through E/M/W and derives every output from them.
// Directed vectors add literal expectations.
// A second instance with CNTBITS=2 exercises counter saturation.
module tb_ctrl_pipe_hazard;

   logic clk;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   bit   run_cmp = 0;

   ctrl_pipe_hazard_if #(.REGBITS(5), .CNTBITS(16)) if1 ();
   ctrl_pipe_hazard_if #(.REGBITS(5), .CNTBITS(2))  if2 ();

   ctrl_pipe_hazard #(.REGBITS(5), .CNTBITS(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   ctrl_pipe_hazard #(.REGBITS(5), .CNTBITS(2)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (if2)
   );

   // both instances see the same decode stream
   assign if2.regwrited = if1.regwrited;
   assign if2.memtoregd = if1.memtoregd;
   assign if2.memwrited = if1.memwrited;
   assign if2.alusrcd   = if1.alusrcd;
   assign if2.regdstd   = if1.regdstd;
   assign if2.branchd   = if1.branchd;
   assign if2.aluopd    = if1.aluopd;
   assign if2.rsd       = if1.rsd;
   assign if2.rtd       = if1.rtd;
   assign if2.rdd       = if1.rdd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic       rw;
      logic       mtr;
      logic       mw;
      logic       as;
      logic       rdst;
      logic [1:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } pkt_t;

   pkt_t        pe, pm, pw;
   int unsigned stall_total;

   function automatic logic [4:0] dest(input pkt_t p);
      return p.rdst ? p.rd : p.rt;
   endfunction

   function automatic pkt_t dec_pkt();
      pkt_t p;
      p.rw   = if1.regwrited;
      p.mtr  = if1.memtoregd;
      p.mw   = if1.memwrited;
      p.as   = if1.alusrcd;
      p.rdst = if1.regdstd;
      p.op   = if1.aluopd;
      p.rs   = if1.rsd;
      p.rt   = if1.rtd;
      p.rd   = if1.rdd;
      return p;
   endfunction

   function automatic logic hazard();
      logic lw;
      logic br;
      lw = pe.mtr && (if1.rsd == pe.rt || if1.rtd == pe.rt);
      br = if1.branchd &&
           ((pe.rw  && (dest(pe) == if1.rsd || dest(pe) == if1.rtd)) ||
            (pm.mtr && (dest(pm) == if1.rsd || dest(pm) == if1.rtd)));
      return lw || br;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] src);
      if (src != 5'd0 && pm.rw && dest(pm) == src) return 2'b10;
      if (src != 5'd0 && pw.rw && dest(pw) == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic exp_fwd_d(input logic [4:0] src);
      return (src != 5'd0) && pm.rw && (dest(pm) == src);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pe          <= '0;
         pm          <= '0;
         pw          <= '0;
         stall_total <= 0;
      end else begin
         pw <= pm;
         pm <= pe;
         pe <= hazard() ? pkt_t'(0) : dec_pkt();
         if (hazard()) stall_total <= stall_total + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clk) begin
      if (run_cmp) begin
         check("cmp_regwritee", 32'(if1.regwritee), 32'(pe.rw));
         check("cmp_memtorege", 32'(if1.memtorege), 32'(pe.mtr));
         check("cmp_memwritee", 32'(if1.memwritee), 32'(pe.mw));
         check("cmp_alusrce",   32'(if1.alusrce),   32'(pe.as));
         check("cmp_regdste",   32'(if1.regdste),   32'(pe.rdst));
         check("cmp_aluope",    32'(if1.aluope),    32'(pe.op));
         check("cmp_rse",       32'(if1.rse),       32'(pe.rs));
         check("cmp_rte",       32'(if1.rte),       32'(pe.rt));
         check("cmp_rde",       32'(if1.rde),       32'(pe.rd));
         check("cmp_writerege", 32'(if1.writerege), 32'(dest(pe)));
         check("cmp_regwritem", 32'(if1.regwritem), 32'(pm.rw));
         check("cmp_memtoregm", 32'(if1.memtoregm), 32'(pm.mtr));
         check("cmp_memwritem", 32'(if1.memwritem), 32'(pm.mw));
         check("cmp_writeregm", 32'(if1.writeregm), 32'(dest(pm)));
         check("cmp_regwritew", 32'(if1.regwritew), 32'(pw.rw));
         check("cmp_memtoregw", 32'(if1.memtoregw), 32'(pw.mtr));
         check("cmp_writeregw", 32'(if1.writeregw), 32'(dest(pw)));
         check("cmp_forwardae", 32'(if1.forwardae), 32'(exp_fwd(pe.rs)));
         check("cmp_forwardbe", 32'(if1.forwardbe), 32'(exp_fwd(pe.rt)));
         check("cmp_forwardad", 32'(if1.forwardad), 32'(exp_fwd_d(if1.rsd)));
         check("cmp_forwardbd", 32'(if1.forwardbd), 32'(exp_fwd_d(if1.rtd)));
         check("cmp_stallf",    32'(if1.stallf),    32'(hazard()));
         check("cmp_stalld",    32'(if1.stalld),    32'(hazard()));
         check("cmp_flushe",    32'(if1.flushe),    32'(hazard()));
         check("cmp_stallcnt",  32'(if1.stallcnt),  (stall_total > 65535) ? 32'd65535 : 32'(stall_total));
         check("cmp_stallcnt2", 32'(if2.stallcnt),  (stall_total > 3) ? 32'd3 : 32'(stall_total));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drv(input string tag,
                      input logic rw, input logic mtr, input logic mw, input logic as,
                      input logic rdst, input logic br, input logic [1:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      if1.regwrited = rw;
      if1.memtoregd = mtr;
      if1.memwrited = mw;
      if1.alusrcd   = as;
      if1.regdstd   = rdst;
      if1.branchd   = br;
      if1.aluopd    = op;
      if1.rsd       = rs;
      if1.rtd       = rt;
      if1.rdd       = rd;
      #1;
      $display("[TB] t=%0t vec %-6s rw=%0b mtr=%0b br=%0b rs=%0d rt=%0d rd=%0d stall=%0b cnt=%0d",
               $time, tag, rw, mtr, br, rs, rt, rd, if1.stalld, if1.stallcnt);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic nop();
      drv("nop", 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic lw9();
      drv("lw9", 1, 1, 0, 1, 0, 0, 2'b00, 5'd1, 5'd9, 5'd0);
   endtask

   task automatic use9();
      drv("use9", 1, 0, 0, 0, 1, 0, 2'b10, 5'd9, 5'd3, 5'd4);
   endtask

   int exp_sat [5] = '{1, 2, 3, 3, 3};

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      nop();
      reset = 1'b0;
      run_cmp = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      // reset state
      check("rst_regwritee", 32'(if1.regwritee), 32'd0);
      check("rst_writeregw", 32'(if1.writeregw), 32'd0);
      check("rst_forwardae", 32'(if1.forwardae), 32'd0);
      check("rst_stalld",    32'(if1.stalld),    32'd0);
      check("rst_stallcnt",  32'(if1.stallcnt),  32'd0);
      reset = 1'b1;
      tick();

      // R-type through E, M, W
      drv("rtype", 1, 0, 0, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd8);
      tick();
      check("r_regdste",   32'(if1.regdste),   32'd1);
      check("r_writerege", 32'(if1.writerege), 32'd8);
      check("r_aluope",    32'(if1.aluope),    32'd2);
      nop();
      tick();
      check("r_regwritem", 32'(if1.regwritem), 32'd1);
      check("r_writeregm", 32'(if1.writeregm), 32'd8);
      tick();
      check("r_regwritew", 32'(if1.regwritew), 32'd1);
      check("r_writeregw", 32'(if1.writeregw), 32'd8);

      // execute forwarding: M priority, W fallback, register 0 excluded
      drv("a10", 1, 0, 0, 0, 1, 0, 2'b10, 5'd0, 5'd0, 5'd10);
      tick();
      drv("b10", 1, 0, 0, 0, 1, 0, 2'b10, 5'd0, 5'd0, 5'd10);
      tick();
      drv("c_rs10", 0, 0, 0, 0, 0, 0, 2'b00, 5'd10, 5'd0, 5'd0);
      tick();
      check("fwd_m", 32'(if1.forwardae), 32'd2);
      drv("d_rs10", 0, 0, 0, 0, 0, 0, 2'b00, 5'd10, 5'd0, 5'd0);
      tick();
      check("fwd_w", 32'(if1.forwardae), 32'd1);
      drv("x_rd0", 1, 0, 0, 0, 1, 0, 2'b10, 5'd0, 5'd0, 5'd0);
      tick();
      nop();
      tick();
      check("fwd_zero_e", 32'(if1.forwardae), 32'd0);
      check("fwd_zero_d", 32'(if1.forwardad), 32'd0);

      // load-use stall and flush
      lw9();
      tick();
      use9();
      check("lw_stallf", 32'(if1.stallf), 32'd1);
      check("lw_stalld", 32'(if1.stalld), 32'd1);
      check("lw_flushe", 32'(if1.flushe), 32'd1);
      tick();
      check("lw_flush_regwritee", 32'(if1.regwritee), 32'd0);
      check("lw_flush_rte",       32'(if1.rte),       32'd0);
      check("lw_stallcnt",        32'(if1.stallcnt),  32'd1);
      check("lw_released",        32'(if1.stalld),    32'd0);
      tick();
      nop();
      tick();

      // branch hazard against E, then resolved by decode forwarding from M
      drv("p5", 1, 0, 0, 0, 1, 0, 2'b10, 5'd0, 5'd0, 5'd5);
      tick();
      drv("beq5", 0, 0, 0, 0, 0, 1, 2'b01, 5'd5, 5'd6, 5'd0);
      check("br_e_stall", 32'(if1.stalld), 32'd1);
      tick();
      check("br_m_stall",    32'(if1.stalld),    32'd0);
      check("br_forwardad",  32'(if1.forwardad), 32'd1);
      check("br_forwardbd",  32'(if1.forwardbd), 32'd0);
      check("br_stallcnt",   32'(if1.stallcnt),  32'd2);
      nop();
      tick();

      // load-use on register 0 still stalls
      drv("lw0", 1, 1, 0, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
      tick();
      nop();
      check("zero_stall", 32'(if1.stalld), 32'd1);
      tick();

      // branch against a load in M
      drv("lw7", 1, 1, 0, 1, 0, 0, 2'b00, 5'd2, 5'd7, 5'd0);
      tick();
      nop();
      tick();
      drv("beq7", 0, 0, 0, 0, 0, 1, 2'b01, 5'd7, 5'd0, 5'd0);
      check("br_mload_stall", 32'(if1.stalld), 32'd1);
      tick();
      nop();
      tick();

      // load-use and branch together: one stall, one count
      drv("lw7", 1, 1, 0, 1, 0, 0, 2'b00, 5'd2, 5'd7, 5'd0);
      tick();
      drv("beq7", 0, 0, 0, 0, 0, 1, 2'b01, 5'd7, 5'd0, 5'd0);
      check("both_stall", 32'(if1.stalld), 32'd1);
      tick();
      check("both_stallcnt", 32'(if1.stallcnt), 32'd5);
      nop();
      tick();

      // counter saturation on the 2-bit instance
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("sat_rst", 32'(if2.stallcnt), 32'd0);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         lw9();
         tick();
         use9();
         check("sat_stall", 32'(if2.stalld), 32'd1);
         tick();
         check("sat_cnt2",  32'(if2.stallcnt), 32'(exp_sat[k]));
         check("sat_cnt16", 32'(if1.stallcnt), 32'(k + 1));
      end

      // asynchronous reset while a load sits in E
      lw9();
      tick();
      use9();
      check("arst_pre_stall", 32'(if1.stalld), 32'd1);
      reset = 1'b0;
      #1;
      check("arst_memtorege", 32'(if1.memtorege), 32'd0);
      check("arst_rte",       32'(if1.rte),       32'd0);
      check("arst_regwritem", 32'(if1.regwritem), 32'd0);
      check("arst_writeregm", 32'(if1.writeregm), 32'd0);
      check("arst_regwritew", 32'(if1.regwritew), 32'd0);
      check("arst_stallcnt",  32'(if1.stallcnt),  32'd0);
      check("arst_stallcnt2", 32'(if2.stallcnt),  32'd0);
      check("arst_stalld",    32'(if1.stalld),    32'd0);
      @(negedge clk);
      #1;
      reset = 1'b1;
      tick();
      check("post_rst_rse",       32'(if1.rse),       32'd9);
      check("post_rst_regwritee", 32'(if1.regwritee), 32'd1);
      check("post_rst_rde",       32'(if1.rde),       32'd4);
      nop();
      repeat (3) tick();

      run_cmp = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_hazard.md
CTRL_PIPE_HAZARD -- requirements
Module: ctrl_pipe_hazard

Interface
REQ-001 Parameter REGBITS, default 5, register-index width.
REQ-002 Parameter CNTBITS, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 regwrited, memtoregd, memwrited, alusrcd, regdstd, branchd  input  1 each  decode-stage control bits.
REQ-006 aluopd  input  2  decode-stage ALU op class.
REQ-007 rsd, rtd, rdd  input  REGBITS each  decode-stage register indices.
REQ-008 regwritee, memtorege, memwritee, alusrce, regdste  output  1 each  execute-stage controls.
REQ-009 aluope  output  2  execute-stage ALU op class.
REQ-010 rse, rte, rde  output  REGBITS each  execute-stage indices.
REQ-011 writerege  output  REGBITS  execute-stage destination register.
REQ-012 regwritem, memtoregm, memwritem  output  1 each; writeregm  output  REGBITS  memory-stage controls.
REQ-013 regwritew, memtoregw  output  1 each; writeregw  output  REGBITS  writeback-stage controls.
REQ-014 forwardae, forwardbe  output  2 each  execute operand forward selects.
REQ-015 forwardad, forwardbd  output  1 each  decode branch-compare forward selects.
REQ-016 stallf, stalld, flushe  output  1 each  hazard controls.
REQ-017 stallcnt  output  CNTBITS  count of stall cycles since reset.

Function
REQ-018 E register SHALL capture all decode inputs each rising edge; when flushe=1 at that edge it SHALL load all-zero controls and indices.
REQ-019 M register SHALL capture regwritee, memtorege, memwritee, writerege each edge; W register SHALL capture M-stage regwrite, memtoreg, writereg each edge; neither stalls nor flushes.
REQ-020 writerege SHALL be combinational: rde if regdste=1, else rte.
REQ-021 forwardae SHALL be 2'b10 if rse!=0, regwritem=1, rse==writeregm; else 2'b01 if rse!=0, regwritew=1, rse==writeregw; else 2'b00; M match has priority.
REQ-022 forwardbe SHALL follow REQ-021 with rte in place of rse.
REQ-023 forwardad SHALL be 1 iff rsd!=0, regwritem=1, rsd==writeregm; forwardbd likewise with rtd.
REQ-024 lwstall SHALL be 1 iff memtorege=1 and (rsd==rte or rtd==rte).
REQ-025 branchstall SHALL be 1 iff branchd=1 and ((regwritee=1 and writerege equals rsd or rtd) or (memtoregm=1 and writeregm equals rsd or rtd)).
REQ-026 stallf, stalld, flushe SHALL each equal lwstall OR branchstall, combinationally, same cycle.
REQ-027 stallcnt SHALL increment by 1 at each edge where stalld=1 and SHALL saturate at all-ones (no wrap).
REQ-028 Latency: decode controls appear on E outputs 1 edge later, M outputs 2 edges, W outputs 3 edges.
REQ-029 Simultaneous lwstall and branchstall SHALL produce a single stall/flush and a single count increment.
REQ-030 Index 0 SHALL never forward; hazard compares for stall SHALL NOT exclude index 0.

Reset
REQ-031 reset=0 SHALL immediately clear E, M, W registers and stallcnt to 0, independent of clk.
REQ-032 With all stage registers zero, forward selects SHALL be 00 and stall/flush 0 unless branchd/memtoreg inputs create a hazard per REQ-024/025.
REQ-033 Reset asserted mid-stall SHALL discard all in-flight controls; first edge after release captures current decode inputs.

Verification
REQ-034 R-type (regwrited=1, regdstd=1, aluopd=10, rdd=8) -> regdste=1, writerege=8 after edge 1; regwritem=1, writeregm=8 after edge 2; regwritew=1, writeregw=8 after edge 3.
REQ-035 LW to rt=9 in E (memtorege=1, rte=9), decode rsd=9 -> stallf=stalld=flushe=1; next edge E controls all 0, stallcnt+1.
REQ-036 writeregm=10, regwritem=1, writeregw=10, regwritew=1, rse=10 -> forwardae=10; with regwritem=0 -> 01; rse=0 -> 00.
REQ-037 BEQ (branchd=1, rsd=5) with regwritee=1, writerege=5 -> stall=1; with regwritem=1, writeregm=5 only -> stall=0, forwardad=1.
REQ-038 CNTBITS=2, hold lwstall 5 cycles -> stallcnt 1,2,3,3,3.
REQ-039 Assert reset low between edges while E holds LW -> all stage outputs and stallcnt 0 before next edge.
